fpu_cmd_sequencer: RTL

- Initiator for the exec_strobe/done_strobe protocol used by the floating-point operation block (ops 0 float_to_int, 1 int_to_float, 2 add, 3 mul).
- Accepts operation requests over a valid/ready interface and buffers them in a small FIFO.
- Issues one request at a time to the FPU, waits for completion or timeout, and returns the result with its tag on a valid/ready response port.
- Sits between the rasterizer/pipeline control logic and the FPU.

---
 rtl/fpu_cmd_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fpu_cmd_sequencer.sv
// Queues FPU requests and runs them one at a time over exec/done strobes, returning result+tag.
// Accept-to-exec 2 cycles, done-to-response 1 cycle; req_ready_o drops when the FIFO is full.
module fpu_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic [3:0]  req_tag_i,
    output logic [1:0]  fpu_op_o,
    output logic [31:0] fpu_a_value_o,
    output logic [31:0] fpu_b_value_o,
    output logic        fpu_exec_strobe_o,
    input  logic [31:0] fpu_z_value_i,
    input  logic        fpu_done_strobe_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_z_o,
    output logic [3:0]  rsp_tag_o,
    output logic        rsp_timeout_o,
    output logic        busy_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    req_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          fifo_full, fifo_empty, push, pop;
    req_t          head;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    op_q;
    logic [31:0]   a_q, b_q, z_q;
    logic [3:0]    tag_q;
    logic          exec_q, vld_q, tmo_q;

    assign fifo_full   = (count_q == CNT_FULL);
    assign fifo_empty  = (count_q == '0);
    assign req_ready_o = !fifo_full;
    assign push        = req_valid_i && !fifo_full;
    assign pop         = (state_q == IDLE) && !fifo_empty;
    assign head        = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{op: req_op_i, a: req_a_i, b: req_b_i, tag: req_tag_i};
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            z_q     <= '0;
            exec_q  <= 1'b0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            exec_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        op_q    <= head.op;
                        a_q     <= head.a;
                        b_q     <= head.b;
                        tag_q   <= head.tag;
                        exec_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Done is checked first so a completion on the last count is not lost.
                    if (fpu_done_strobe_i) begin
                        z_q     <= fpu_z_value_i;
                        tmo_q   <= 1'b0;
                        vld_q   <= 1'b1;
                        state_q <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        z_q     <= '0;
                        tmo_q   <= 1'b1;
                        vld_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        vld_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fpu_op_o          = op_q;
    assign fpu_a_value_o     = a_q;
    assign fpu_b_value_o     = b_q;
    assign fpu_exec_strobe_o = exec_q;
    assign rsp_valid_o       = vld_q;
    assign rsp_z_o           = z_q;
    assign rsp_tag_o         = tag_q;
    assign rsp_timeout_o     = tmo_q;
    assign busy_o            = (state_q != IDLE) || !fifo_empty;
endmodule
